// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue side of the 32-bit multicycle ALU.
// Decodes a MIPS opcode/funct into an ALU op and operands, registers them so
// the external combinational ALU settles for a full cycle, then captures the
// ALU outputs into a response register held until the consumer takes it.
module alu_issue_ctrl #(
  parameter bit         TRAP_EN  = 1'b1,
  parameter logic [3:0] RESET_OP = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm16,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carryout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_carry,
  output logic        out_wr_en,
  output logic        out_taken,
  output logic        exc_overflow,
  output logic        exc_illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [31:0] alu_a_q, alu_b_q;
  logic [3:0]  alu_op_q;
  logic        illegal_q, trap_q, wr_q, beq_q, bne_q;

  logic [31:0] res_q;
  logic        carry_q, wr_en_q, taken_q, ovf_q, ill_q;

  logic [31:0] dec_a, dec_b;
  logic [3:0]  dec_op;
  logic        dec_illegal, dec_trap, dec_wr, dec_beq, dec_bne;
  logic [31:0] imm_sext, imm_zext;

  logic accept, consume, cap_ovf, cap_taken;

  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign imm_zext = {16'h0000, imm16};

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == RESP);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // Instruction decode: operand selection, ALU op and per-instruction flags
  always_comb begin
    dec_a       = rs_data;
    dec_b       = rt_data;
    dec_op      = OP_AND;
    dec_illegal = 1'b0;
    dec_trap    = 1'b0;
    dec_wr      = 1'b1;
    dec_beq     = 1'b0;
    dec_bne     = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin dec_op = OP_ADD; dec_trap = 1'b1; end
          6'h21: dec_op = OP_ADD;
          6'h22: begin dec_op = OP_SUB; dec_trap = 1'b1; end
          6'h23: dec_op = OP_SUB;
          6'h24: dec_op = OP_AND;
          6'h25: dec_op = OP_OR;
          6'h2A: dec_op = OP_SLT;
          6'h00: begin dec_a = rt_data; dec_b = {27'b0, shamt}; dec_op = OP_SLL; end
          6'h02: begin dec_a = rt_data; dec_b = {27'b0, shamt}; dec_op = OP_SRL; end
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h08: begin dec_b = imm_sext; dec_op = OP_ADD; dec_trap = 1'b1; end
      6'h09: begin dec_b = imm_sext; dec_op = OP_ADD; end
      6'h0C: begin dec_b = imm_zext; dec_op = OP_AND; end
      6'h0D: begin dec_b = imm_zext; dec_op = OP_OR; end
      6'h0A: begin dec_b = imm_sext; dec_op = OP_SLT; end
      6'h23: begin dec_b = imm_sext; dec_op = OP_ADD; end
      6'h2B: begin dec_b = imm_sext; dec_op = OP_ADD; dec_wr = 1'b0; end
      6'h04: begin dec_op = OP_SUB; dec_wr = 1'b0; dec_beq = 1'b1; end
      6'h05: begin dec_op = OP_SUB; dec_wr = 1'b0; dec_bne = 1'b1; end
      default: dec_illegal = 1'b1;
    endcase
    // Undecodable instructions feed the ALU zeros so nothing toggles for them
    if (dec_illegal) begin
      dec_a    = 32'h0;
      dec_b    = 32'h0;
      dec_op   = OP_AND;
      dec_wr   = 1'b0;
      dec_trap = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: fixed two-cycle walk from accept to response
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = EXEC;
      EXEC: state_d = CAPT;
      CAPT: state_d = RESP;
      RESP: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU drive registers: loaded at accept, held through CAPT/RESP, parked when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q  <= 32'h0;
      alu_b_q  <= 32'h0;
      alu_op_q <= RESET_OP;
    end else if (accept) begin
      alu_a_q  <= dec_a;
      alu_b_q  <= dec_b;
      alu_op_q <= dec_op;
    end else if (consume) begin
      alu_a_q  <= 32'h0;
      alu_b_q  <= 32'h0;
      alu_op_q <= RESET_OP;
    end
  end

  // Per-instruction control bits remembered for the capture cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      trap_q    <= 1'b0;
      wr_q      <= 1'b0;
      beq_q     <= 1'b0;
      bne_q     <= 1'b0;
    end else if (accept) begin
      illegal_q <= dec_illegal;
      trap_q    <= dec_trap;
      wr_q      <= dec_wr;
      beq_q     <= dec_beq;
      bne_q     <= dec_bne;
    end
  end

  assign cap_ovf   = TRAP_EN & trap_q & alu_overflow;
  assign cap_taken = (beq_q & alu_zero) | (bne_q & ~alu_zero);

  // Response register: sampled from the ALU in CAPT, held until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= 32'h0;
      carry_q <= 1'b0;
      wr_en_q <= 1'b0;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else if (state_q == CAPT) begin
      res_q   <= illegal_q ? 32'h0 : alu_result;
      carry_q <= illegal_q ? 1'b0 : alu_carryout;
      wr_en_q <= wr_q & ~cap_ovf;
      taken_q <= cap_taken;
      ovf_q   <= cap_ovf;
      ill_q   <= illegal_q;
    end else if (consume) begin
      res_q   <= 32'h0;
      carry_q <= 1'b0;
      wr_en_q <= 1'b0;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign out_result   = res_q;
  assign out_carry    = carry_q;
  assign out_wr_en    = wr_en_q;
  assign out_taken    = taken_q;
  assign exc_overflow = ovf_q;
  assign exc_illegal  = ill_q;

endmodule
